// File: rtl/decode.sv
// decode: ID stage of the 5-stage pipeline. Holds the 32x32 register file,
// decodes the supported MIPS subset, resolves branches/jumps (one delay slot)
// and replays through IF's jump port when a hazard is seen, since IF has no
// stall input. A replay is followed by exactly one squashed cycle.
module decode #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] pc_if_id,
  input  logic [31:0]          ir_if_id,
  input  logic                 wb_en,
  input  logic [4:0]           wb_reg,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_dst,
  output logic                 jump,
  output logic [WORD_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] pc_id_ex,
  output logic [WORD_SIZE-1:0] rs_data_id_ex,
  output logic [WORD_SIZE-1:0] rt_data_id_ex,
  output logic [WORD_SIZE-1:0] imm_id_ex,
  output logic [4:0]           rs_id_ex,
  output logic [4:0]           rt_id_ex,
  output logic [4:0]           dst_id_ex,
  output logic [3:0]           alu_op_id_ex,
  output logic                 alu_src_id_ex,
  output logic                 reg_write_id_ex,
  output logic                 mem_read_id_ex,
  output logic                 mem_write_id_ex
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08,
                         FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_SLT = 4'd4, ALU_SLL = 4'd5,
                         ALU_SRL = 4'd6, ALU_LUI = 4'd7, ALU_LINK = 4'd8;
  // Replay control: RUN decodes normally, SQUASH turns the next fetch into a bubble.
  localparam logic [0:0] ST_RUN = 1'b0, ST_SQUASH = 1'b1;
  localparam logic [WORD_SIZE-1:0] PC_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  logic [5:0]           opcode, funct;
  logic [4:0]           rs, rt, rd, shamt;
  logic [WORD_SIZE-1:0] imm_sext, rs_val, rt_val;
  logic [WORD_SIZE-1:0] rf_q [32];
  logic [0:0]           state_q, state_d;

  logic                 dec_valid, uses_rs, uses_rt;
  logic                 is_beq, is_bne, is_jr, is_j, is_brj;
  logic                 dec_rw, dec_mr, dec_mw, dec_asrc;
  logic [3:0]           dec_op;
  logic [4:0]           dec_dst;
  logic [WORD_SIZE-1:0] dec_imm, br_target;
  logic                 br_taken, src_match, hz, bubble;

  assign opcode   = ir_if_id[31:26];
  assign rs       = ir_if_id[25:21];
  assign rt       = ir_if_id[20:16];
  assign rd       = ir_if_id[15:11];
  assign shamt    = ir_if_id[10:6];
  assign funct    = ir_if_id[5:0];
  assign imm_sext = {{(WORD_SIZE-16){ir_if_id[15]}}, ir_if_id[15:0]};

  // Register reads bypass a same-cycle writeback; r0 is hard-wired to zero.
  assign rs_val = (rs == 5'd0) ? '0 : (wb_en && wb_reg == rs) ? wb_data : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : (wb_en && wb_reg == rt) ? wb_data : rf_q[rt];

  // Register file write port; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_reg != 5'd0) begin
      rf_q[wb_reg] <= wb_data;
    end
  end

  // Instruction decode: control, source usage, destination and immediate.
  always_comb begin
    dec_valid = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_jr = 1'b0; is_j = 1'b0;
    dec_rw = 1'b0; dec_mr = 1'b0; dec_mw = 1'b0; dec_asrc = 1'b0;
    dec_op = ALU_ADD; dec_dst = rt; dec_imm = imm_sext;
    case (opcode)
      OP_RTYPE: begin
        dec_dst = rd;
        case (funct)
          FN_ADD: begin dec_valid = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; dec_rw = 1'b1; dec_op = ALU_ADD; end
          FN_SUB: begin dec_valid = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; dec_rw = 1'b1; dec_op = ALU_SUB; end
          FN_AND: begin dec_valid = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; dec_rw = 1'b1; dec_op = ALU_AND; end
          FN_OR:  begin dec_valid = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; dec_rw = 1'b1; dec_op = ALU_OR;  end
          FN_SLT: begin dec_valid = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; dec_rw = 1'b1; dec_op = ALU_SLT; end
          FN_SLL: begin
            dec_valid = 1'b1; uses_rt = 1'b1; dec_rw = 1'b1; dec_op = ALU_SLL;
            dec_imm = {{(WORD_SIZE-5){1'b0}}, shamt};
          end
          FN_SRL: begin
            dec_valid = 1'b1; uses_rt = 1'b1; dec_rw = 1'b1; dec_op = ALU_SRL;
            dec_imm = {{(WORD_SIZE-5){1'b0}}, shamt};
          end
          FN_JR:  begin dec_valid = 1'b1; uses_rs = 1'b1; is_jr = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin dec_valid = 1'b1; uses_rs = 1'b1; dec_rw = 1'b1; dec_asrc = 1'b1; dec_op = ALU_ADD; end
      OP_SLTI: begin dec_valid = 1'b1; uses_rs = 1'b1; dec_rw = 1'b1; dec_asrc = 1'b1; dec_op = ALU_SLT; end
      OP_ANDI: begin
        dec_valid = 1'b1; uses_rs = 1'b1; dec_rw = 1'b1; dec_asrc = 1'b1; dec_op = ALU_AND;
        dec_imm = {{(WORD_SIZE-16){1'b0}}, ir_if_id[15:0]};
      end
      OP_ORI: begin
        dec_valid = 1'b1; uses_rs = 1'b1; dec_rw = 1'b1; dec_asrc = 1'b1; dec_op = ALU_OR;
        dec_imm = {{(WORD_SIZE-16){1'b0}}, ir_if_id[15:0]};
      end
      OP_LUI: begin
        dec_valid = 1'b1; dec_rw = 1'b1; dec_asrc = 1'b1; dec_op = ALU_LUI;
        dec_imm = {ir_if_id[15:0], {(WORD_SIZE-16){1'b0}}};
      end
      OP_LW:  begin dec_valid = 1'b1; uses_rs = 1'b1; dec_rw = 1'b1; dec_mr = 1'b1; dec_asrc = 1'b1; end
      OP_SW:  begin dec_valid = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; dec_mw = 1'b1; dec_asrc = 1'b1; end
      OP_BEQ: begin dec_valid = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; is_beq = 1'b1; dec_op = ALU_SUB; end
      OP_BNE: begin dec_valid = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; is_bne = 1'b1; dec_op = ALU_SUB; end
      OP_J:   begin dec_valid = 1'b1; is_j = 1'b1; end
      OP_JAL: begin
        // Link returns past the delay slot.
        dec_valid = 1'b1; is_j = 1'b1; dec_rw = 1'b1; dec_asrc = 1'b1; dec_op = ALU_LINK;
        dec_dst = 5'd31; dec_imm = pc_if_id + PC_ONE;
      end
      default: ;
    endcase
  end

  assign is_brj = is_beq | is_bne | is_jr;

  // Branch/jump decision and target on the bypassed operands.
  always_comb begin
    br_taken  = 1'b0;
    br_target = pc_if_id + imm_sext;
    if (is_beq) br_taken = (rs_val == rt_val);
    if (is_bne) br_taken = (rs_val != rt_val);
    if (is_j) begin
      br_taken  = 1'b1;
      br_target = {pc_if_id[WORD_SIZE-1 -: 6], ir_if_id[25:0]};
    end
    if (is_jr) begin
      br_taken  = 1'b1;
      br_target = rs_val;
    end
  end

  // A hazard replays the current instruction; the squashed cycle never raises one.
  assign src_match = (uses_rs && ex_dst == rs) || (uses_rt && ex_dst == rt);
  assign hz        = (state_q == ST_RUN) && (ex_dst != 5'd0) && src_match &&
                     (ex_mem_read || (is_brj && ex_reg_write));
  assign bubble    = (state_q == ST_SQUASH) || hz || !dec_valid;
  assign jump      = rst && (state_q == ST_RUN) && (hz || br_taken);
  assign addr      = hz ? (pc_if_id - PC_ONE) : br_target;
  assign state_d   = hz ? ST_SQUASH : ST_RUN;

  // Replay state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // ID/EX pipeline register; control is forced to a bubble when not issuing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_id_ex        <= '0;
      rs_data_id_ex   <= '0;
      rt_data_id_ex   <= '0;
      imm_id_ex       <= '0;
      rs_id_ex        <= '0;
      rt_id_ex        <= '0;
      dst_id_ex       <= '0;
      alu_op_id_ex    <= '0;
      alu_src_id_ex   <= 1'b0;
      reg_write_id_ex <= 1'b0;
      mem_read_id_ex  <= 1'b0;
      mem_write_id_ex <= 1'b0;
    end else begin
      pc_id_ex        <= pc_if_id;
      rs_data_id_ex   <= rs_val;
      rt_data_id_ex   <= rt_val;
      imm_id_ex       <= dec_imm;
      rs_id_ex        <= rs;
      rt_id_ex        <= rt;
      dst_id_ex       <= bubble ? 5'd0 : dec_dst;
      alu_op_id_ex    <= bubble ? ALU_ADD : dec_op;
      alu_src_id_ex   <= dec_asrc & ~bubble;
      reg_write_id_ex <= dec_rw & ~bubble;
      mem_read_id_ex  <= dec_mr & ~bubble;
      mem_write_id_ex <= dec_mw & ~bubble;
    end
  end

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed and randomized checks of the ID stage against a
// mnemonic-level reference model of the instruction set and hazard rules.
`timescale 1ns/1ps
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if_id, ir_if_id, wb_data;
  logic        wb_en, ex_reg_write, ex_mem_read;
  logic [4:0]  wb_reg, ex_dst;
  logic        jump;
  logic [31:0] addr, pc_id_ex, rs_data_id_ex, rt_data_id_ex, imm_id_ex;
  logic [4:0]  rs_id_ex, rt_id_ex, dst_id_ex;
  logic [3:0]  alu_op_id_ex;
  logic        alu_src_id_ex, reg_write_id_ex, mem_read_id_ex, mem_write_id_ex;

  decode #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst), .pc_if_id(pc_if_id), .ir_if_id(ir_if_id),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .jump(jump), .addr(addr), .pc_id_ex(pc_id_ex),
    .rs_data_id_ex(rs_data_id_ex), .rt_data_id_ex(rt_data_id_ex),
    .imm_id_ex(imm_id_ex), .rs_id_ex(rs_id_ex), .rt_id_ex(rt_id_ex),
    .dst_id_ex(dst_id_ex), .alu_op_id_ex(alu_op_id_ex),
    .alu_src_id_ex(alu_src_id_ex), .reg_write_id_ex(reg_write_id_ex),
    .mem_read_id_ex(mem_read_id_ex), .mem_write_id_ex(mem_write_id_ex)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and checker ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {
    M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_JR,
    M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LUI, M_LW, M_SW,
    M_BEQ, M_BNE, M_J, M_JAL, M_BAD
  } mn_t;

  typedef struct packed {
    logic        bubble, chk_op, chk_src, chk_dst;
    logic        rw, mr, mw, asrc;
    logic [3:0]  op;
    logic [4:0]  dst;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs, rt;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  logic [31:0]  ref_rf [32];
  bit           ref_sq;
  bit           pend_hz;

  function automatic mn_t classify(input logic [31:0] ir);
    logic [5:0] op = ir[31:26];
    logic [5:0] fn = ir[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return M_ADD;  6'h22: return M_SUB;  6'h24: return M_AND;
        6'h25: return M_OR;   6'h2A: return M_SLT;  6'h00: return M_SLL;
        6'h02: return M_SRL;  6'h08: return M_JR;
        default: return M_BAD;
      endcase
    end
    case (op)
      6'h02: return M_J;    6'h03: return M_JAL;  6'h04: return M_BEQ;
      6'h05: return M_BNE;  6'h08: return M_ADDI; 6'h0A: return M_SLTI;
      6'h0C: return M_ANDI; 6'h0D: return M_ORI;  6'h0F: return M_LUI;
      6'h23: return M_LW;   6'h2B: return M_SW;
      default: return M_BAD;
    endcase
  endfunction

  function automatic logic [31:0] enc(input mn_t m, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [15:0] imm, input logic [25:0] tgt);
    case (m)
      M_ADD:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      M_SUB:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      M_AND:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      M_OR:   return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      M_SLT:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      M_SLL:  return {6'h00, 5'd0, rt, rd, sh, 6'h00};
      M_SRL:  return {6'h00, 5'd0, rt, rd, sh, 6'h02};
      M_JR:   return {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
      M_ADDI: return {6'h08, rs, rt, imm};
      M_SLTI: return {6'h0A, rs, rt, imm};
      M_ANDI: return {6'h0C, rs, rt, imm};
      M_ORI:  return {6'h0D, rs, rt, imm};
      M_LUI:  return {6'h0F, 5'd0, rt, imm};
      M_LW:   return {6'h23, rs, rt, imm};
      M_SW:   return {6'h2B, rs, rt, imm};
      M_BEQ:  return {6'h04, rs, rt, imm};
      M_BNE:  return {6'h05, rs, rt, imm};
      M_J:    return {6'h02, tgt};
      M_JAL:  return {6'h03, tgt};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] rd_ref(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_reg == r) return wb_data;
    return ref_rf[r];
  endfunction

  function automatic logic [3:0] op_of(input mn_t m);
    case (m)
      M_SUB: return 4'd1;
      M_AND, M_ANDI: return 4'd2;
      M_OR, M_ORI: return 4'd3;
      M_SLT, M_SLTI: return 4'd4;
      M_SLL: return 4'd5;
      M_SRL: return 4'd6;
      M_LUI: return 4'd7;
      M_JAL: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic model_eval(output logic e_jump, output logic [31:0] e_addr,
                            output exp_t e, output bit e_hz);
    mn_t         m   = classify(ir_if_id);
    logic [4:0]  rs  = ir_if_id[25:21];
    logic [4:0]  rt  = ir_if_id[20:16];
    logic [31:0] a   = rd_ref(rs);
    logic [31:0] b   = rd_ref(rt);
    logic [31:0] sx  = {{16{ir_if_id[15]}}, ir_if_id[15:0]};
    bit reads_rs = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_JR, M_ADDI, M_ANDI,
                             M_ORI, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE};
    bit reads_rt = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_SW, M_BEQ, M_BNE};
    bit ctl_flow = m inside {M_BEQ, M_BNE, M_JR};
    bit dep   = (ex_dst != 0) && ((reads_rs && ex_dst == rs) || (reads_rt && ex_dst == rt));
    bit hz    = !ref_sq && dep && (ex_mem_read || (ctl_flow && ex_reg_write));
    bit taken = (m == M_BEQ && a == b) || (m == M_BNE && a != b) || (m inside {M_J, M_JAL, M_JR});
    e_hz   = hz;
    e_jump = rst && !ref_sq && (hz || taken);
    if (hz)                            e_addr = pc_if_id - 32'd1;
    else if (m inside {M_BEQ, M_BNE})  e_addr = pc_if_id + sx;
    else if (m == M_JR)                e_addr = a;
    else                               e_addr = {pc_if_id[31:26], ir_if_id[25:0]};
    e = '0;
    e.pc     = pc_if_id;
    e.bubble = ref_sq || hz || m == M_BAD || m == M_J;
    if (!e.bubble) begin
      e.rw = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL,
                       M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LUI, M_LW, M_JAL};
      e.mr = (m == M_LW);
      e.mw = (m == M_SW);
      e.asrc    = m inside {M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LUI, M_LW, M_SW, M_JAL};
      e.chk_op  = e.rw || e.mr || e.mw;
      e.chk_src = e.chk_op && !(m inside {M_SLL, M_SRL});
      e.chk_dst = e.rw;
      e.op  = op_of(m);
      if (m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL}) e.dst = ir_if_id[15:11];
      else if (m == M_JAL) e.dst = 5'd31;
      else                 e.dst = rt;
      case (m)
        M_ANDI, M_ORI: e.imm = {16'd0, ir_if_id[15:0]};
        M_LUI:         e.imm = {ir_if_id[15:0], 16'd0};
        M_SLL, M_SRL:  e.imm = {27'd0, ir_if_id[10:6]};
        M_JAL:         e.imm = pc_if_id + 32'd1;
        default:       e.imm = sx;
      endcase
      e.a = a; e.b = b; e.rs = rs; e.rt = rt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [31:0] ir, input logic [31:0] pc,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic xrw, input logic xmr, input logic [4:0] xd);
    ir_if_id = ir; pc_if_id = pc; wb_en = we; wb_reg = wr; wb_data = wd;
    ex_reg_write = xrw; ex_mem_read = xmr; ex_dst = xd;
  endtask

  // Combinational phase: predict, then check jump/addr away from the edge.
  task automatic step_pre();
    logic        e_jump;
    logic [31:0] e_addr;
    exp_t        e;
    bit          e_hz;
    model_eval(e_jump, e_addr, e, e_hz);
    pend_hz = e_hz;
    exp_q.push_back(e);
    #2;
    check_eq("jump", 32'(jump), 32'(e_jump));
    if (e_jump) check_eq("addr", addr, e_addr);
  endtask

  // Clock edge: advance the model, then compare the ID/EX register.
  task automatic step_post();
    exp_t e;
    @(posedge clk);
    if (wb_en && wb_reg != 5'd0) ref_rf[wb_reg] = wb_data;
    ref_sq = pend_hz;
    #1;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check_eq("pc_id_ex", pc_id_ex, e.pc);
      check_eq("reg_write", 32'(reg_write_id_ex), 32'(e.rw));
      check_eq("mem_read", 32'(mem_read_id_ex), 32'(e.mr));
      check_eq("mem_write", 32'(mem_write_id_ex), 32'(e.mw));
      if (e.bubble) begin
        check_eq("alu_src_bubble", 32'(alu_src_id_ex), 32'd0);
      end else begin
        check_eq("rs_data", rs_data_id_ex, e.a);
        check_eq("rt_data", rt_data_id_ex, e.b);
        check_eq("imm", imm_id_ex, e.imm);
        check_eq("rs_idx", 32'(rs_id_ex), 32'(e.rs));
        check_eq("rt_idx", 32'(rt_id_ex), 32'(e.rt));
      end
      if (e.chk_op)  check_eq("alu_op", 32'(alu_op_id_ex), 32'(e.op));
      if (e.chk_src) check_eq("alu_src", 32'(alu_src_id_ex), 32'(e.asrc));
      if (e.chk_dst) check_eq("dst", 32'(dst_id_ex), 32'(e.dst));
    end
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    ref_sq = 1'b0;
    pend_hz = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_jump"}, 32'(jump), 32'd0);
    check_eq({tag, "_pc"}, pc_id_ex, 32'd0);
    check_eq({tag, "_imm"}, imm_id_ex, 32'd0);
    check_eq({tag, "_rs_data"}, rs_data_id_ex, 32'd0);
    check_eq({tag, "_ctl"}, {28'd0, reg_write_id_ex, mem_read_id_ex, mem_write_id_ex, alu_src_id_ex}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    set_in(32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b1;

    // addi r1,r0,5 at pc 1
    set_in(enc(M_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'd5, 26'd0), 32'd1, 0, 0, 0, 0, 0, 0);
    step();
    check_eq("addi_rw", 32'(reg_write_id_ex), 32'd1);
    check_eq("addi_dst", 32'(dst_id_ex), 32'd1);
    check_eq("addi_imm", imm_id_ex, 32'd5);
    check_eq("addi_src", 32'(alu_src_id_ex), 32'd1);
    check_eq("addi_op", 32'(alu_op_id_ex), 32'd0);
    check_eq("addi_pc", pc_id_ex, 32'd1);

    // Same-cycle writeback bypass, and r0 stays zero.
    set_in(enc(M_ADD, 5'd3, 5'd3, 5'd4, 5'd0, 16'd0, 26'd0), 32'd2, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
    step();
    check_eq("bypass_rs", rs_data_id_ex, 32'hDEADBEEF);
    check_eq("bypass_rt", rt_data_id_ex, 32'hDEADBEEF);
    set_in(enc(M_ADD, 5'd0, 5'd0, 5'd6, 5'd0, 16'd0, 26'd0), 32'd3, 1, 5'd0, 32'h12345678, 0, 0, 0);
    step();
    check_eq("r0_bypass", rs_data_id_ex, 32'd0);
    set_in(enc(M_ADD, 5'd3, 5'd0, 5'd6, 5'd0, 16'd0, 26'd0), 32'd4, 0, 0, 0, 0, 0, 0);
    step();
    check_eq("r3_stored", rs_data_id_ex, 32'hDEADBEEF);
    check_eq("r0_stored", rt_data_id_ex, 32'd0);

    // beq r1,r2,-3 at pc 0x10: taken with 7/7, not taken with 7/8.
    set_in(32'd0, 32'd5, 1, 5'd1, 32'd7, 0, 0, 0);
    step();
    set_in(enc(M_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFD, 26'd0), 32'h10, 1, 5'd2, 32'd7, 0, 0, 0);
    step_pre();
    check_eq("beq_taken_jump", 32'(jump), 32'd1);
    check_eq("beq_taken_addr", addr, 32'h0D);
    step_post();
    set_in(enc(M_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFD, 26'd0), 32'h10, 1, 5'd2, 32'd8, 0, 0, 0);
    step_pre();
    check_eq("beq_not_taken", 32'(jump), 32'd0);
    step_post();

    // jal 0x123 at pc 0x40, then its delay slot.
    set_in(enc(M_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h123), 32'h40, 0, 0, 0, 0, 0, 0);
    step_pre();
    check_eq("jal_jump", 32'(jump), 32'd1);
    check_eq("jal_addr", addr, 32'h123);
    step_post();
    check_eq("jal_dst", 32'(dst_id_ex), 32'd31);
    check_eq("jal_imm", imm_id_ex, 32'h41);
    check_eq("jal_op", 32'(alu_op_id_ex), 32'd8);
    set_in(enc(M_ADDI, 5'd0, 5'd7, 5'd0, 5'd0, 16'd9, 26'd0), 32'h41, 0, 0, 0, 0, 0, 0);
    step_pre();
    check_eq("slot_jump", 32'(jump), 32'd0);
    step_post();
    check_eq("slot_rw", 32'(reg_write_id_ex), 32'd1);
    check_eq("slot_dst", 32'(dst_id_ex), 32'd7);

    // Load-use replay: bubble, squashed cycle, then the add issues.
    set_in(enc(M_ADD, 5'd2, 5'd1, 5'd5, 5'd0, 16'd0, 26'd0), 32'h21, 0, 0, 0, 1, 1, 5'd2);
    step_pre();
    check_eq("lu_jump", 32'(jump), 32'd1);
    check_eq("lu_addr", addr, 32'h20);
    step_post();
    check_eq("lu_bubble", 32'(reg_write_id_ex), 32'd0);
    set_in(enc(M_ADD, 5'd2, 5'd1, 5'd5, 5'd0, 16'd0, 26'd0), 32'h22, 0, 0, 0, 1, 1, 5'd2);
    step_pre();
    check_eq("sq_jump", 32'(jump), 32'd0);
    step_post();
    check_eq("sq_bubble", 32'(reg_write_id_ex), 32'd0);
    set_in(enc(M_ADD, 5'd2, 5'd1, 5'd5, 5'd0, 16'd0, 26'd0), 32'h21, 0, 0, 0, 0, 0, 0);
    step_pre();
    check_eq("replay_jump", 32'(jump), 32'd0);
    step_post();
    check_eq("replay_rw", 32'(reg_write_id_ex), 32'd1);
    check_eq("replay_dst", 32'(dst_id_ex), 32'd5);
    check_eq("replay_rs_data", rs_data_id_ex, 32'd8);

    // Reset during the squash cycle discards the pending squash.
    set_in(enc(M_BNE, 5'd2, 5'd0, 5'd0, 5'd0, 16'd4, 26'd0), 32'h50, 0, 0, 0, 1, 0, 5'd2);
    step();
    rst = 1'b0;
    #1;
    check_cleared("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_in(enc(M_BEQ, 5'd0, 5'd0, 5'd0, 5'd0, 16'd2, 26'd0), 32'h30, 0, 0, 0, 0, 0, 0);
    step_pre();
    check_eq("post_reset_jump", 32'(jump), 32'd1);
    check_eq("post_reset_addr", addr, 32'h32);
    step_post();
    set_in(enc(M_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'd5, 26'd0), 32'h31, 0, 0, 0, 0, 0, 0);
    step();
    check_eq("post_reset_rw", 32'(reg_write_id_ex), 32'd1);

    // Randomized traffic with a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      mn_t         m  = mn_t'($urandom_range(0, 19));
      logic [31:0] ir;
      logic [15:0] imm = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      logic        xmr = ($urandom_range(0, 3) == 0);
      if (m == M_BAD) ir = $urandom;
      else ir = enc(m, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)), imm, 26'($urandom));
      set_in(ir, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             xmr | 1'($urandom_range(0, 1)), xmr, 5'($urandom_range(0, 7)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- ID stage of the 5-stage pipeline, directly downstream of the IF stage.
- Consumes pc_if_id/ir_if_id. pc_if_id is the word address of the instruction *after* the one in ir_if_id.
- Holds the 32x32 register file, generates control, and resolves branches/jumps (one architectural delay slot). Drives jump/addr back to IF.
- Detects load-use and branch-operand hazards and replays via IF's jump port, since IF has no stall input.

Parameters:
WORD_SIZE, 32, datapath/PC width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
pc_if_id  in  32  PC of next instruction (from IF)
ir_if_id  in  32  instruction word (from IF)
wb_en  in  1  writeback enable
wb_reg  in  5  writeback register index
wb_data  in  32  writeback data
ex_reg_write  in  1  instruction in EX writes a register
ex_mem_read  in  1  instruction in EX is a load
ex_dst  in  5  EX destination register
jump  out  1  redirect IF (combinational)
addr  out  32  redirect target (combinational)
pc_id_ex  out  32  registered pc_if_id
rs_data_id_ex  out  32  operand A
rt_data_id_ex  out  32  operand B
imm_id_ex  out  32  extended immediate
rs_id_ex  out  5  rs index
rt_id_ex  out  5  rt index
dst_id_ex  out  5  destination index (rd, rt, or 31)
alu_op_id_ex  out  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 srl, 7 lui, 8 pass-link
alu_src_id_ex  out  1  B operand = immediate
reg_write_id_ex  out  1  writes a register
mem_read_id_ex  out  1  load
mem_write_id_ex  out  1  store

Behaviour:
- Async reset (rst=0):
  - all *_id_ex outputs 0; squash register 0; all 32 registers 0.
  - jump=0 while rst=0.
- Register file:
  - r0 reads 0; writes to r0 are ignored.
  - Write on posedge when wb_en=1.
  - Read bypass: if wb_en and wb_reg==src and src!=0, the read returns wb_data in the same cycle.
- Decoded subset:
  - R-type: add, sub, and, or, slt, sll, srl, jr.
  - I-type: addi, andi, ori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Any other opcode/funct decodes as a bubble.
- Immediate extension:
  - andi/ori zero-extend.
  - lui places imm in [31:16].
  - sll/srl put shamt in imm[4:0].
  - All others sign-extend.
- Branch/jump resolution (combinational, this cycle):
  - beq/bne compare the bypassed register values; if taken, jump=1 and addr=pc_if_id+sext(imm). Arithmetic is mod 2^32, word-addressed.
  - j/jal: jump=1, addr={pc_if_id[31:26],ir[25:0]}.
  - jr: jump=1, addr=rs value.
  - jal: dst=31, alu_op=8, imm_id_ex=pc_if_id+1 (return past the delay slot).
  - The delay-slot instruction is never squashed.
- Hazard (hz), computed combinationally:
  - (ex_mem_read and ex_dst!=0 and ex_dst equals a used source of the current instruction), or
  - (current is beq/bne/jr and ex_reg_write and ex_dst!=0 and ex_dst equals a used source).
- Hazard response:
  - On hz (and squash=0): jump=1, addr=pc_if_id-1 (replay), all control outputs to ID/EX zeroed (bubble), squash<=1.
  - hz takes priority over the branch decision.
- Squash:
  - When squash=1, the incoming instruction is treated as a bubble, jump=0 and hazard checking is suppressed; squash<=0 on the same edge.
  - A replay therefore costs exactly 2 bubble cycles.
- Pipeline registers: all *_id_ex outputs update every posedge. Latency ID→EX is 1 cycle.
- Bubble: reg_write, mem_read, mem_write and alu_src are 0; the data fields are don't-care but must hold no X on control.
- Reset asserted mid-operation: outputs clear immediately; the pending squash is discarded.

Test Plan:
- Reset low, then release; addi r1,r0,5 with pc_if_id=1 → next edge: reg_write_id_ex=1, dst=1, imm=5, alu_src=1, alu_op=0, pc_id_ex=1.
- wb_en=1, wb_reg=3, wb_data=0xDEADBEEF in the same cycle as add r4,r3,r3 → rs/rt_data_id_ex=0xDEADBEEF; a write to r0 reads back 0.
- beq r1,r2,-3 with r1==r2==7, pc_if_id=0x10 → jump=1, addr=0x0D; with r2=8 → jump=0.
- jal 0x123 at pc_if_id=0x40 → addr=0x123, dst=31, imm_id_ex=0x41; the delay slot issues normally.
- ex_mem_read=1, ex_dst=2, add r5,r2,r1 at pc_if_id=0x21 → jump=1, addr=0x20, bubble; the next cycle is squashed (jump=0, bubble); on replay with ex_mem_read=0 the add issues.
- Assert rst during the squash cycle → outputs 0 immediately; after release the first instruction is not squashed.
